// File: rtl/key_event_pkg.sv
// Shared types and default timing for the key_event block: FSM state type,
// its 2-bit encoding, and default hold/repeat intervals for a 50 MHz clock.
package key_event_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_PRESSED_ENC = 2'd1;
  localparam logic [1:0] ST_HELD_ENC    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE_ENC,
    PRESSED = ST_PRESSED_ENC,
    HELD    = ST_HELD_ENC
  } key_state_e;

  localparam int CLK_HZ            = 50_000_000;
  localparam int LONG_CYCLES_DEF   = CLK_HZ;       // 1 s hold for a long press
  localparam int REPEAT_CYCLES_DEF = CLK_HZ / 5;   // 200 ms between repeats
  localparam int CNT_W_DEF         = 26;

endpackage

// File: rtl/key_event_if.sv
// Key level in, single-cycle UI strobes and debug state out.
interface key_event_if;
  import key_event_pkg::*;

  // No back-pressure: every *_pulse is a one-cycle strobe the consumer must
  // take in the cycle it is high; there is no valid/ready pair on this bus.
  logic       key_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  key_state_e state;

  modport master (
    output key_in,
    input  press_pulse, release_pulse, click_pulse, long_pulse,
           repeat_pulse, held, state
  );

  modport slave (
    input  key_in,
    output press_pulse, release_pulse, click_pulse, long_pulse,
           repeat_pulse, held, state
  );

endinterface

// File: rtl/key_hold_timer.sv
// Up-counter with clear/enable and a terminal-count compare against a
// muxed limit; shared between the long-press and repeat intervals.
module key_hold_timer
  import key_event_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // The owner clears on terminal count, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = en && (cnt == limit);

endmodule

// File: rtl/key_event.sv
// Turns a debounced active-low key level into press/release/click/long/repeat
// strobes. Auto-repeat is compiled in with KEY_EVENT_AUTO_REPEAT_EN.
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  key_event_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYCLES - 1);

  key_state_e       state;
  logic             key_q;
  logic             press_q;
  logic             release_q;
  logic             click_q;
  logic             long_q;
  logic             rep_q;
  logic             held_q;

  logic             press_evt;
  logic             release_evt;
  logic             timer_en;
  logic             timer_clr;
  logic             tc;
  logic             tc_hit;
  logic [CNT_W-1:0] limit;

  always_comb begin
    press_evt   = (state == IDLE) && !bus.key_in && key_q;
    release_evt = ((state == PRESSED) || (state == HELD)) && bus.key_in;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
    timer_en    = (state == PRESSED) || (state == HELD);
`else
    // Without auto-repeat the timer idles at 0 in HELD; only release matters.
    timer_en    = (state == PRESSED);
`endif
    limit       = (state == HELD) ? REP_LIM : LONG_LIM;
    // Release wins over a terminal count landing in the same cycle.
    tc_hit      = tc && !release_evt;
    timer_clr   = press_evt || release_evt || tc_hit;
  end

  key_hold_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (limit),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      key_q     <= bus.key_in;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (press_evt) begin
            state   <= PRESSED;
            press_q <= 1'b1;
          end
        end
        PRESSED: begin
          if (release_evt) begin
            state     <= IDLE;
            release_q <= 1'b1;
            click_q   <= 1'b1;
          end else if (tc_hit) begin
            state  <= HELD;
            long_q <= 1'b1;
            held_q <= 1'b1;
          end
        end
        HELD: begin
          if (release_evt) begin
            state     <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else if (tc_hit) begin
            rep_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  // rep_q can only set when the timer runs in HELD, i.e. with auto-repeat.
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.click_pulse   = click_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = rep_q;
  assign bus.held          = held_q;
  assign bus.state         = state;

endmodule
